elevator_call_panel: RTL and testbench
======================================

Name: elevator_call_panel

Overview:
Request-side front end for the 3-floor elevator controller. It latches hall/cab button presses and picks the next target floor using direction-preferring nearest-first order. It drives the 2-bit request code to the controller and holds it until the controller reports arrival (floor == target, moving == 0). It then runs a door-open interval, clears the served call, and picks the next one.

Parameters:
ARRIVE_CYCLES, 2, consecutive qualified cycles of floor==target && moving==0 required to confirm arrival (1..15)
DOOR_CYCLES, 8, cycles door_open stays asserted after confirmed arrival (1..255)
TIMEOUT_CYCLES, 64, max cycles in SERVE before fault is declared (2..1023)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
btn  in  3  call buttons, bit i = floor i; sampled every cycle, level or pulse
floor  in  2  current floor from controller (00/01/10; 11 invalid)
moving  in  1  controller moving status
request  out  2  request code to controller: 00 floor 0, 01 floor 1, 10 floor 2; never 11
pending  out  3  latched outstanding calls, bit i = floor i
door_open  out  1  high during DOOR state
busy  out  1  high in SERVE or DOOR
fault  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values: request=00, pending=000, door_open=0, busy=0, fault=0, state=IDLE, dir_up=1, park=00, all counters 0.
- Latching: pending[i] sets on any cycle with btn[i]=1. Exception: btn[i]=1 is absorbed (no set) in the cycle pending[i] is cleared, and for the whole of DOOR when i == target. Set is visible one cycle after the press edge.
- States: IDLE, SERVE, DOOR. All outputs registered.
- IDLE: request = park, the last served floor (00 after reset). If pending != 0, select target, load request=target, set busy, go SERVE. Request changes on the edge after pending becomes visible, so press-to-request latency is 2 cycles.
- Selection, with cur = floor input (11 treated as 00):
  - If dir_up: choose the nearest pending floor >= cur; if none, the nearest < cur.
  - If !dir_up: mirror of the above.
  - dir_up <= 1 if target > cur, 0 if target < cur, unchanged if equal.
  - A call at the current floor is selected first and arrives after ARRIVE_CYCLES.
- SERVE: request holds target, stable and never changing mid-serve. New presses only update pending.
  - Arrival counter increments on each cycle with floor==target && moving==0. It resets to 0 on any cycle that fails the condition, including floor==11.
  - Counter reaches ARRIVE_CYCLES: clear pending[target], park <= target, door counter <= DOOR_CYCLES, go DOOR.
  - Timeout counter increments every SERVE cycle. On reaching TIMEOUT_CYCLES without arrival: fault <= 1, clear pending[target], go IDLE. Arrival takes precedence if both occur in the same cycle.
- DOOR: door_open=1, request holds target. The door counter decrements. At 1, door_open drops on the next edge and the block goes IDLE; with pending != 0, selection happens in the following IDLE cycle, not in DOOR.
- busy = (state != IDLE).
- fault does not stop operation; service continues with later calls.
- Reset mid-operation (any state): asynchronous return to reset values; calls in flight are lost.
- Counter widths: sized to hold their parameter maximum; no wrap possible in legal use.

Test Plan:
- Reset, btn=010 pulse 1 cycle, floor=00 moving=0 -> pending=010 at +1, request=01 and busy=1 at +2. Then floor=01 moving=0 for 2 cycles -> pending=000, door_open=1 for exactly 8 cycles, then IDLE with request=01 (parked).
- Parked at floor 1, dir_up=1, pending set to 101 simultaneously -> target floor 2 (request=10) first, then floor 0 (request=00); dir_up ends 0.
- In SERVE toward floor 2: floor=10 moving=0 for 1 cycle, then moving=1, then 2 quiet cycles -> arrival confirmed only after the second consecutive quiet pair; no early door_open.
- btn[2] held high throughout DOOR at floor 2 -> pending[2] stays 0; after DOOR exits, IDLE remains idle with request=10.
- Target floor 1, floor input stuck at 00 -> after 64 SERVE cycles fault=1, pending[1]=0, IDLE. A later call to floor 0 is still served; fault stays 1.
- Reset asserted mid-DOOR with pending=110 -> all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/elevator_call_panel.sv
// ---------------------------------------------------------------------------
// elevator_call_panel
// Request-side front end for the 3-floor elevator controller. Latches
// hall/cab calls, picks the next target floor (direction-preferring,
// nearest first), holds the request code until the controller confirms
// arrival, runs the door interval, clears the served call and moves on.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   btn[2:0]   call buttons, bit i = floor i (level or pulse)
//   floor[1:0] current floor from controller (11 is invalid)
//   moving     controller moving status
//   request    target floor code to controller (00/01/10, never 11)
//   pending    latched outstanding calls, bit i = floor i
//   door_open  high while the door interval runs
//   busy       high while serving a call or holding the door
//   fault      sticky serve-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module elevator_call_panel #(
  parameter int ARRIVE_CYCLES  = 2,
  parameter int DOOR_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [1:0] floor,
  input  logic       moving,
  output logic [1:0] request,
  output logic [2:0] pending,
  output logic       door_open,
  output logic       busy,
  output logic       fault
);

  localparam int AW = $clog2(ARRIVE_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [AW-1:0] ARR_LAST  = AW'(ARRIVE_CYCLES);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;

  state_t        state, state_n;
  logic          dir_up, dir_up_n;
  logic [1:0]    park, park_n;
  logic [1:0]    request_n;
  logic [2:0]    pending_n;
  logic [AW-1:0] arr_cnt, arr_cnt_n;
  logic [DW-1:0] door_cnt, door_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          fault_n, door_open_n, busy_n;

  logic [1:0]    cur;
  logic [1:0]    sel;
  logic [2:0]    tgt_mask;
  logic [2:0]    clr;
  logic [2:0]    absorb;
  logic          arr_hit;

  // Nearest call in the preferred direction (current floor included),
  // falling back to the nearest call behind.
  function automatic logic [1:0] pick_target(input logic [2:0] calls,
                                             input logic [1:0] here,
                                             input logic       up);
    logic [1:0] res;
    logic       found;
    res   = here;
    found = 1'b0;
    if (up) begin
      for (int i = 0; i < 3; i++)
        if (!found && calls[i] && (i >= int'(here))) begin
          res   = 2'(i);
          found = 1'b1;
        end
      for (int i = 2; i >= 0; i--)
        if (!found && calls[i] && (i < int'(here))) begin
          res   = 2'(i);
          found = 1'b1;
        end
    end else begin
      for (int i = 2; i >= 0; i--)
        if (!found && calls[i] && (i <= int'(here))) begin
          res   = 2'(i);
          found = 1'b1;
        end
      for (int i = 0; i < 3; i++)
        if (!found && calls[i] && (i > int'(here))) begin
          res   = 2'(i);
          found = 1'b1;
        end
    end
    return res;
  endfunction

  always_comb begin
    state_n    = state;
    dir_up_n   = dir_up;
    park_n     = park;
    request_n  = request;
    arr_cnt_n  = arr_cnt;
    door_cnt_n = door_cnt;
    to_cnt_n   = to_cnt;
    fault_n    = fault;
    clr        = 3'b000;
    absorb     = 3'b000;

    // An invalid floor code is treated as floor 0 for selection only.
    cur      = (floor == 2'b11) ? 2'b00 : floor;
    sel      = pick_target(pending, cur, dir_up);
    tgt_mask = 3'b001 << request;
    arr_hit  = (floor == request) && !moving;

    case (state)
      IDLE: begin
        if (pending != 3'b000) begin
          request_n = sel;
          state_n   = SERVE;
          arr_cnt_n = '0;
          to_cnt_n  = '0;
          if (sel > cur)      dir_up_n = 1'b1;
          else if (sel < cur) dir_up_n = 1'b0;
        end
      end
      SERVE: begin
        arr_cnt_n = arr_hit ? arr_cnt + AW'(1) : '0;
        to_cnt_n  = to_cnt + TW'(1);
        // Arrival wins over a timeout landing on the same cycle.
        if (arr_hit && (arr_cnt + AW'(1) == ARR_LAST)) begin
          clr        = tgt_mask;
          park_n     = request;
          door_cnt_n = DOOR_LOAD;
          arr_cnt_n  = '0;
          to_cnt_n   = '0;
          state_n    = DOOR;
        end else if (to_cnt + TW'(1) == TO_LAST) begin
          fault_n   = 1'b1;
          clr       = tgt_mask;
          request_n = park;
          arr_cnt_n = '0;
          to_cnt_n  = '0;
          state_n   = IDLE;
        end
      end
      DOOR: begin
        // Presses for the floor whose door is open are already satisfied.
        absorb     = tgt_mask;
        door_cnt_n = door_cnt - DW'(1);
        if (door_cnt == DW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    pending_n   = (pending & ~clr) | (btn & ~(clr | absorb));
    door_open_n = (state_n == DOOR);
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      park      <= 2'b00;
      request   <= 2'b00;
      pending   <= 3'b000;
      arr_cnt   <= '0;
      door_cnt  <= '0;
      to_cnt    <= '0;
      fault     <= 1'b0;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      dir_up    <= dir_up_n;
      park      <= park_n;
      request   <= request_n;
      pending   <= pending_n;
      arr_cnt   <= arr_cnt_n;
      door_cnt  <= door_cnt_n;
      to_cnt    <= to_cnt_n;
      fault     <= fault_n;
      door_open <= door_open_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_elevator_call_panel.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_panel
// Self-checking bench for elevator_call_panel. Expected request codes are
// queued when calls are pressed and compared when the panel starts a serve.
// ---------------------------------------------------------------------------
module tb_elevator_call_panel;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [1:0] floor;
  logic       moving;
  logic [1:0] request;
  logic [2:0] pending;
  logic       door_open;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  elevator_call_panel #(
    .ARRIVE_CYCLES (2),
    .DOOR_CYCLES   (8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .floor    (floor),
    .moving   (moving),
    .request  (request),
    .pending  (pending),
    .door_open(door_open),
    .busy     (busy),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until busy reaches the wanted level; n = cycles taken or -1.
  task automatic wait_busy(input logic want, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (busy === want) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 3'b000; floor = 2'b00; moving = 1'b0;
    #3;
    checks++;
    if ({request, pending, door_open, busy, fault} !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got %b expected 00000000", {request, pending, door_open, busy, fault});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({request, pending, door_open, busy, fault} !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 00000000", {request, pending, door_open, busy, fault});
    end
  endtask

  task automatic test_basic();
    logic [1:0] e;
    int n;
    floor = 2'b00; moving = 1'b0;
    btn = 3'b010;
    exp_q.push_back(2'b01);
    tick();
    btn = 3'b000;
    checks++;
    if (pending !== 3'b010) begin errors++; $display("FAIL basic_latch: got %b expected 010", pending); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_early: got %b expected 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL basic_req: queue empty, got %b", request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL basic_req: got %b expected %b", request, e); end
    end
    floor = 2'b01;
    tick();
    checks++;
    if (door_open !== 1'b0) begin errors++; $display("FAIL basic_early_door: got %b expected 0", door_open); end
    tick();
    checks++;
    if ({door_open, pending} !== 4'b1000) begin
      errors++; $display("FAIL basic_arrive: door/pending got %b expected 1000", {door_open, pending});
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open === 1'b1) n++;
      else break;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL basic_door_len: got %0d expected 8", n); end
    checks++;
    if ({busy, request} !== 3'b001) begin
      errors++; $display("FAIL basic_parked: busy/request got %b expected 001", {busy, request});
    end
  endtask

  task automatic test_direction();
    logic [1:0] e;
    int n;
    btn = 3'b101;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    tick();
    btn = 3'b000;
    wait_busy(1'b1, 5, n);
    checks++;
    if (exp_q.size() == 0 || n < 0) begin errors++; $display("FAIL dir_first: n=%0d got %b", n, request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL dir_first: got %b expected %b", request, e); end
    end
    floor = 2'b10;
    wait_busy(1'b0, 30, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL dir_serve2_timeout: got %0d expected >0", n); end
    checks++;
    if ({request, pending} !== 5'b10001) begin
      errors++; $display("FAIL dir_after2: req/pending got %b expected 10001", {request, pending});
    end
    wait_busy(1'b1, 3, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL dir_reselect_delay: got %0d expected 1", n); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL dir_second: queue empty, got %b", request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL dir_second: got %b expected %b", request, e); end
    end
    checks++;
    if (dut.dir_up !== 1'b0) begin errors++; $display("FAIL dir_flag: got %b expected 0", dut.dir_up); end
    floor = 2'b00;
    wait_busy(1'b0, 30, n);
    checks++;
    if ({request, pending} !== 5'b00000) begin
      errors++; $display("FAIL dir_after0: req/pending got %b expected 00000", {request, pending});
    end
  endtask

  task automatic test_arrival_glitch();
    logic [1:0] e;
    int n;
    btn = 3'b100;
    exp_q.push_back(2'b10);
    tick();
    btn = 3'b000;
    wait_busy(1'b1, 5, n);
    checks++;
    if (exp_q.size() == 0 || n < 0) begin errors++; $display("FAIL glitch_req: n=%0d got %b", n, request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL glitch_req: got %b expected %b", request, e); end
    end
    floor = 2'b10; moving = 1'b0;
    tick();
    checks++;
    if (door_open !== 1'b0) begin errors++; $display("FAIL glitch_q1: got %b expected 0", door_open); end
    moving = 1'b1;
    tick();
    checks++;
    if (door_open !== 1'b0) begin errors++; $display("FAIL glitch_moving: got %b expected 0", door_open); end
    moving = 1'b0;
    tick();
    checks++;
    if (door_open !== 1'b0) begin errors++; $display("FAIL glitch_q1b: got %b expected 0", door_open); end
    tick();
    checks++;
    if ({door_open, pending} !== 4'b1000) begin
      errors++; $display("FAIL glitch_arrive: door/pending got %b expected 1000", {door_open, pending});
    end
  endtask

  task automatic test_door_absorb();
    int n;
    btn = 3'b100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open === 1'b1) n++;
      else break;
    end
    btn = 3'b000;
    checks++;
    if (n !== 7) begin errors++; $display("FAIL absorb_door_len: got %0d expected 7", n); end
    checks++;
    if (pending !== 3'b000) begin errors++; $display("FAIL absorb_pending: got %b expected 000", pending); end
    tick(); tick();
    checks++;
    if ({busy, request} !== 3'b010) begin
      errors++; $display("FAIL absorb_idle: busy/request got %b expected 010", {busy, request});
    end
  endtask

  task automatic test_timeout();
    logic [1:0] e;
    int n;
    btn = 3'b010;
    exp_q.push_back(2'b01);
    tick();
    btn = 3'b000;
    wait_busy(1'b1, 5, n);
    checks++;
    if (exp_q.size() == 0 || n < 0) begin errors++; $display("FAIL to_req: n=%0d got %b", n, request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL to_req: got %b expected %b", request, e); end
    end
    floor = 2'b00;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (fault === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL to_cycles: got %0d expected 64", n); end
    checks++;
    if ({busy, pending, request} !== 6'b000010) begin
      errors++; $display("FAIL to_state: busy/pending/req got %b expected 000010", {busy, pending, request});
    end
    btn = 3'b001;
    exp_q.push_back(2'b00);
    tick();
    btn = 3'b000;
    wait_busy(1'b1, 5, n);
    checks++;
    if (exp_q.size() == 0 || n < 0) begin errors++; $display("FAIL to_next_req: n=%0d got %b", n, request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL to_next_req: got %b expected %b", request, e); end
    end
    wait_busy(1'b0, 30, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL to_next_serve: got %0d expected >0", n); end
    checks++;
    if ({fault, request} !== 3'b100) begin
      errors++; $display("FAIL to_sticky: fault/request got %b expected 100", {fault, request});
    end
  endtask

  task automatic test_reset_mid_door();
    logic [1:0] e;
    int n;
    btn = 3'b001;
    exp_q.push_back(2'b00);
    tick();
    btn = 3'b000;
    wait_busy(1'b1, 5, n);
    checks++;
    if (exp_q.size() == 0 || n < 0) begin errors++; $display("FAIL rst_req: n=%0d got %b", n, request); end
    else begin
      e = exp_q.pop_front();
      if (request !== e) begin errors++; $display("FAIL rst_req: got %b expected %b", request, e); end
    end
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (door_open === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL rst_same_floor_arrive: got %0d expected 2", n); end
    btn = 3'b110;
    tick();
    btn = 3'b000;
    checks++;
    if ({door_open, pending, fault} !== 5'b11101) begin
      errors++; $display("FAIL rst_pre: door/pending/fault got %b expected 11101", {door_open, pending, fault});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({request, pending, door_open, busy, fault} !== 8'h00) begin
      errors++; $display("FAIL rst_async: got %b expected 00000000", {request, pending, door_open, busy, fault});
    end
    #2;
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, pending} !== 4'b0000) begin
      errors++; $display("FAIL rst_after: busy/pending got %b expected 0000", {busy, pending});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_direction();
    test_arrival_glitch();
    test_door_absorb();
    test_timeout();
    test_reset_mid_door();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
